inst_rom_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported, asynchronously read instruction ROM. It shares the ROM between the IF stage fetch port and a debug/loader read port, using round-robin arbitration on ties. It registers the ROM read data, returning it one cycle after grant with a valid strobe. It also generates the IF stall request for ctrl, handles pipeline flush of an in-flight fetch, and rejects misaligned or out-of-range addresses without touching the ROM.

---
 rtl/inst_rom_arbiter.sv | 82 ++++++++
 tb/tb_inst_rom_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// Shares the single-ported async instruction ROM between the IF fetch port and a debug read port.
// Latency: grant is combinational in cycle N, registered response (rvalid/rdata/err) in cycle N+1.
// Backpressure: a requester holds req/addr until gnt; the loser of a tie sees gnt=0 (IF also raises stallreq_if).
module inst_rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              flush,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic              stallreq_if,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  // 0 = IF was granted last, 1 = DBG was granted last; the other port wins a tie
  logic              last_grant;
  logic              if_sel;
  logic              dbg_sel;
  logic [ADDR_W-1:0] gnt_addr;
  logic              legal;

  // Arbitration depends only on requests and last_grant, never on address
  // legality, so there is no combinational path from rom_inst back to gnt.
  always_comb begin
    if_sel      = if_req & (~dbg_req | last_grant);
    dbg_sel     = dbg_req & (~if_req | ~last_grant);
    if_gnt      = ~rst & if_sel;
    dbg_gnt     = ~rst & dbg_sel;
    stallreq_if = ~rst & if_req & ~if_sel;
    gnt_addr    = if_gnt ? if_addr : dbg_addr;
    legal       = (gnt_addr[1:0] == 2'b00) &&
                  (gnt_addr[ADDR_W-1:DEPTH_LOG2+2] == '0);
    rom_ce      = (if_gnt | dbg_gnt) & legal;
    rom_addr    = rom_ce ? gnt_addr : '0;
  end

  // Register responses for the granted port and advance the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      dbg_err    <= 1'b0;
    end else begin
      // A flush only hides the IF strobe; the access and data capture still happen.
      if_rvalid  <= if_gnt & ~flush;
      dbg_rvalid <= dbg_gnt;
      if (if_gnt) begin
        if_rdata <= legal ? rom_inst : '0;
        if_err   <= ~legal;
      end
      if (dbg_gnt) begin
        dbg_rdata <= legal ? rom_inst : '0;
        dbg_err   <= ~legal;
      end
      if (if_gnt) begin
        last_grant <= 1'b0;
      end else if (dbg_gnt) begin
        last_grant <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: directed scenarios followed by random two-port traffic.
// Expected responses are queued per port and popped by an independent monitor.
// The ROM is modelled as a pure function of the word address.
module tb_inst_rom_arbiter;

  localparam int DEPTH_LOG2 = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dbg_req, flush;
  logic [31:0] if_addr, dbg_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic        dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] if_rdata, dbg_rdata;
  logic        stallreq_if, rom_ce;
  logic [31:0] rom_addr, rom_inst;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t q_if[$];
  resp_t q_dbg[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  logic        m_last_dbg = 1'b1;
  logic        prev_rst = 1'b0;
  logic [31:0] sh_if = '0;
  logic [31:0] sh_dbg = '0;
  logic        m_g_if, m_g_dbg;

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .flush(flush),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .stallreq_if(stallreq_if), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return ({2'b00, a[31:2]} * 32'h0001_0003) ^ 32'h1357_9BDF;
  endfunction

  // ROM: asynchronous read of the word at rom_addr
  assign rom_inst = rom_fn(rom_addr);

  function automatic logic is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < (32'd4 << DEPTH_LOG2));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: evaluated at the falling edge once inputs are stable.
  task automatic model_eval();
    logic        eg_if, eg_dbg, lg, exp_ce;
    logic [31:0] ga, exp_ra, d;
    resp_t       r;
    if (prev_rst) begin
      chk("post_rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("post_rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
      chk("post_rst_errs", {30'd0, if_err, dbg_err}, 32'd0);
    end
    eg_if  = !rst && if_req && (!dbg_req || m_last_dbg);
    eg_dbg = !rst && dbg_req && !eg_if;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, eg_if});
    chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, eg_dbg});
    chk("stallreq_if", {31'd0, stallreq_if}, {31'd0, !rst && if_req && !eg_if});
    ga     = eg_if ? if_addr : dbg_addr;
    lg     = is_legal(ga);
    exp_ce = (eg_if || eg_dbg) && lg;
    exp_ra = exp_ce ? ga : 32'd0;
    chk("rom_ce", {31'd0, rom_ce}, {31'd0, exp_ce});
    chk("rom_addr", rom_addr, exp_ra);
    chk("if_rdata_hold", if_rdata, sh_if);
    chk("dbg_rdata_hold", dbg_rdata, sh_dbg);
    d = lg ? rom_fn(ga) : 32'd0;
    if (rst) begin
      sh_if = '0;
      sh_dbg = '0;
      m_last_dbg = 1'b1;
    end else begin
      if (eg_if) begin
        sh_if = d;
        if (!flush) begin
          r.cyc = cyc + 1; r.err = !lg; r.data = d;
          q_if.push_back(r);
        end
        m_last_dbg = 1'b0;
      end
      if (eg_dbg) begin
        sh_dbg = d;
        r.cyc = cyc + 1; r.err = !lg; r.data = d;
        q_dbg.push_back(r);
        m_last_dbg = 1'b1;
      end
    end
    prev_rst = rst;
    m_g_if   = eg_if;
    m_g_dbg  = eg_dbg;
  endtask

  task automatic cycle(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da, input logic fl);
    @(posedge clk);
    #1;
    rst = r; if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da; flush = fl;
    @(negedge clk);
    model_eval();
  endtask

  // Monitor: pops the expected response whenever a port presents rvalid
  always @(negedge clk) begin
    resp_t e;
    if (if_rvalid) begin
      checks++;
      if (q_if.size() == 0 || q_if[0].cyc != cyc) begin
        errors++;
        $display("FAIL if_resp_unexpected cyc=%0d actual rvalid=1 required rvalid=0", cyc);
      end else begin
        e = q_if.pop_front();
        if (if_err !== e.err || if_rdata !== e.data) begin
          errors++;
          $display("FAIL if_resp cyc=%0d actual err=%b data=%h required err=%b data=%h",
                   cyc, if_err, if_rdata, e.err, e.data);
        end
      end
    end else if (q_if.size() > 0 && q_if[0].cyc == cyc) begin
      checks++; errors++;
      $display("FAIL if_resp_missing cyc=%0d actual rvalid=0 required rvalid=1", cyc);
      e = q_if.pop_front();
    end
    if (dbg_rvalid) begin
      checks++;
      if (q_dbg.size() == 0 || q_dbg[0].cyc != cyc) begin
        errors++;
        $display("FAIL dbg_resp_unexpected cyc=%0d actual rvalid=1 required rvalid=0", cyc);
      end else begin
        e = q_dbg.pop_front();
        if (dbg_err !== e.err || dbg_rdata !== e.data) begin
          errors++;
          $display("FAIL dbg_resp cyc=%0d actual err=%b data=%h required err=%b data=%h",
                   cyc, dbg_err, dbg_rdata, e.err, e.data);
        end
      end
    end else if (q_dbg.size() > 0 && q_dbg[0].cyc == cyc) begin
      checks++; errors++;
      $display("FAIL dbg_resp_missing cyc=%0d actual rvalid=0 required rvalid=1", cyc);
      e = q_dbg.pop_front();
    end
  end

  function automatic logic [31:0] rand_addr();
    int kind;
    kind = $urandom_range(0, 9);
    if (kind == 0) return ($urandom_range(0, 4095) << 2) | $urandom_range(1, 3);
    if (kind == 1) return ($urandom | 32'h0008_0000) & 32'hFFFF_FFFC;
    return $urandom_range(0, 32'h1FFFF) << 2;
  endfunction

  initial begin
    logic        p_if, p_dbg;
    logic [31:0] a_if, a_dbg;
    rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0; flush = 1'b0;
    if_addr = '0; dbg_addr = '0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // sequential IF fetches, no debug traffic
    cycle(0, 1, 32'h0, 0, 0, 0);
    cycle(0, 1, 32'h4, 0, 0, 0);
    cycle(0, 1, 32'h8, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // first tie after reset goes to IF, DBG held until granted
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h10, 1, 32'h20, 0);
    cycle(0, 0, 0, 1, 32'h20, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // continuous contention: strict alternation
    for (int i = 0; i < 6; i++) cycle(0, 1, 32'h40 + 4 * i, 1, 32'h80 + 4 * i, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // rejected debug accesses: misaligned and out of range
    cycle(0, 0, 0, 1, 32'h6, 0);
    cycle(0, 0, 0, 1, 32'h0008_0000, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // flush suppresses only the same-cycle IF grant's response
    cycle(0, 1, 32'h100, 0, 0, 1);
    cycle(0, 1, 32'h104, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 32'h200, 1);
    cycle(0, 0, 0, 0, 0, 0);

    // reset while IF requests, after IF was granted last; then a tie
    cycle(0, 1, 32'h30, 0, 0, 0);
    cycle(1, 1, 32'h34, 0, 0, 0);
    cycle(0, 1, 32'h38, 1, 32'h3C, 0);
    cycle(0, 0, 0, 1, 32'h3C, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // random traffic with hold-until-grant requesters
    p_if = 1'b0; p_dbg = 1'b0; a_if = '0; a_dbg = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!p_if && $urandom_range(0, 2) != 0) begin p_if = 1'b1; a_if = rand_addr(); end
      if (!p_dbg && $urandom_range(0, 2) != 0) begin p_dbg = 1'b1; a_dbg = rand_addr(); end
      cycle($urandom_range(0, 49) == 0, p_if, a_if, p_dbg, a_dbg, $urandom_range(0, 3) == 0);
      if (m_g_if) p_if = 1'b0;
      if (m_g_dbg) p_dbg = 1'b0;
    end
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("if_queue_drained", q_if.size(), 32'd0);
    chk("dbg_queue_drained", q_dbg.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
